regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a per-register busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle writeback data/busy to the read ports.
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveReg,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZERO0 = (R0_ZERO != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_wr_en;
    logic              w_rsv_en;
    logic              w_set_new;
    logic              w_clr_new;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    // Register-0 writes/reservations are dropped when it is hardwired; strobes are inert under reset.
    assign w_wr_en  = RegWrite && !RST && !(ZERO0 && (WriteReg == '0));
    assign w_rsv_en = Reserve && !RST && !(ZERO0 && (ReserveReg == '0));

    // A reservation landing on the register being written keeps it busy (newer producer).
    assign w_set_new = w_rsv_en && !r_busy[ReserveReg];
    assign w_clr_new = w_wr_en && r_busy[WriteReg] &&
                       !(w_rsv_en && (ReserveReg == WriteReg));
    assign w_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(w_set_new) - (ADDR_W+1)'(w_clr_new);

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en)
            w_busy_nxt[WriteReg] = 1'b0;
        if (w_rsv_en)
            w_busy_nxt[ReserveReg] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_en)
                r_regs[WriteReg] <= WriteData;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        ReadData1 = r_regs[ReadReg1];
        ReadData2 = r_regs[ReadReg2];
        Busy1     = r_busy[ReadReg1];
        Busy2     = r_busy[ReadReg2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
            Busy1     = w_rsv_en && (ReserveReg == ReadReg1);
        end
        if (w_wr_en && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
            Busy2     = w_rsv_en && (ReserveReg == ReadReg2);
        end
`endif
        if (ZERO0 && (ReadReg1 == '0))
            ReadData1 = '0;
        if (ZERO0 && (ReadReg2 == '0))
            ReadData2 = '0;
    end

    assign BusyCount = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand sequences (reset, bypass), randomized run vs. model.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] ReadReg1;
    logic [AW-1:0] ReadReg2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          Reserve;
    logic [AW-1:0] ReserveReg;
    logic          Busy1;
    logic          Busy2;
    logic [AW:0]   BusyCount;

    int total = 0;
    int bad   = 0;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1)) dut (
        .CLK(CLK), .RST(RST),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Reserve(Reserve), .ReserveReg(ReserveReg),
        .Busy1(Busy1), .Busy2(Busy2), .BusyCount(BusyCount)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain arrays, count recomputed as a popcount.
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (RegWrite && WriteReg != 0) begin
            m_mem[WriteReg]  = WriteData;
            m_busy[WriteReg] = 1'b0;
        end
        if (Reserve && ReserveReg != 0)
            m_busy[ReserveReg] = 1'b1;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && WriteReg == idx) return WriteData;
`endif
        return m_mem[idx];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && WriteReg == idx && idx != 0)
            return Reserve && ReserveReg == idx;
`endif
        return m_busy[idx];
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += m_busy[i];
        return (AW+1)'(n);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                           input logic eb1, input logic eb2, input logic [AW:0] ec);
        chk({tag, ".rd1"}, 64'(ReadData1), 64'(e1));
        chk({tag, ".rd2"}, 64'(ReadData2), 64'(e2));
        chk({tag, ".b1"},  64'(Busy1),     64'(eb1));
        chk({tag, ".b2"},  64'(Busy2),     64'(eb2));
        chk({tag, ".cnt"}, 64'(BusyCount), 64'(ec));
    endtask

    task automatic idle();
        RegWrite = 1'b0; Reserve = 1'b0;
    endtask

    // Drive at negedge, let the edge happen, mirror it in the model, return at next negedge.
    task automatic clk_edge();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    typedef struct {
        logic          rw;
        logic [AW-1:0] wreg;
        logic [DW-1:0] wdat;
        logic          rsv;
        logic [AW-1:0] rsvreg;
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic          eb1;
        logic          eb2;
        logic [AW:0]   ec;
    } vec_t;

    vec_t vt [12];

    initial begin
        // {rw, wreg, wdat, rsv, rsvreg, rr1, rr2, e1, e2, eb1, eb2, cnt} observed after the edge
        vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
        vt[1]  = '{1, 0, 32'h1,        0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0, 0};
        vt[2]  = '{0, 0, 32'h0,        1, 3, 3, 7, 32'h0, 32'h0, 1, 0, 1};
        vt[3]  = '{0, 0, 32'h0,        1, 7, 3, 7, 32'h0, 32'h0, 1, 1, 2};
        vt[4]  = '{0, 0, 32'h0,        1, 3, 3, 7, 32'h0, 32'h0, 1, 1, 2};
        vt[5]  = '{1, 3, 32'h33,       0, 0, 3, 7, 32'h33, 32'h0, 0, 1, 1};
        vt[6]  = '{1, 9, 32'h99,       0, 0, 9, 3, 32'h99, 32'h33, 0, 0, 1};
        vt[7]  = '{1, 4, 32'h55,       1, 4, 4, 7, 32'h55, 32'h0, 1, 1, 2};
        vt[8]  = '{1, 7, 32'h77,       1, 6, 6, 7, 32'h0, 32'h77, 1, 0, 2};
        vt[9]  = '{0, 0, 32'h0,        1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 2};
        vt[10] = '{1, 6, 32'h66,       1, 6, 6, 4, 32'h66, 32'h55, 1, 1, 2};
        vt[11] = '{1, 4, 32'h44,       0, 0, 4, 6, 32'h44, 32'h66, 0, 1, 1};

        RST = 1'b1; idle();
        WriteReg = '0; WriteData = '0; ReserveReg = '0; ReadReg1 = 5; ReadReg2 = 9;
        model_reset();
        #1;
        chk_all("reset", '0, '0, 1'b0, 1'b0, '0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed table
        for (int k = 0; k < 12; k++) begin
            RegWrite = vt[k].rw; WriteReg = vt[k].wreg; WriteData = vt[k].wdat;
            Reserve = vt[k].rsv; ReserveReg = vt[k].rsvreg;
            ReadReg1 = vt[k].rr1; ReadReg2 = vt[k].rr2;
            clk_edge();
            idle();
            #1;
            chk_all($sformatf("vec%0d", k), vt[k].e1, vt[k].e2, vt[k].eb1, vt[k].eb2, vt[k].ec);
        end

        // Asynchronous reset mid-run, strobes held active must be ignored
        RegWrite = 1'b1; WriteReg = 4; WriteData = 32'hABCD;
        Reserve = 1'b1; ReserveReg = 6; ReadReg1 = 4; ReadReg2 = 6;
        RST = 1'b1;
        #1;
        chk_all("arst", '0, '0, 1'b0, 1'b0, '0);
        @(posedge CLK); #1;
        chk_all("arst_edge", '0, '0, 1'b0, 1'b0, '0);
        @(negedge CLK);
        idle(); RST = 1'b0;
        model_reset();

        // Bypass sequence: reg 8 busy holding 0x10, then writeback 0x20 while reading it
        RegWrite = 1'b1; WriteReg = 8; WriteData = 32'h10;
        clk_edge();
        idle(); Reserve = 1'b1; ReserveReg = 8;
        clk_edge();
        idle();
        RegWrite = 1'b1; WriteReg = 8; WriteData = 32'h20; ReadReg1 = 8; ReadReg2 = 8;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk_all("byp_same", 32'h20, 32'h20, 1'b0, 1'b0, 1);
`else
        chk_all("byp_same", 32'h10, 32'h10, 1'b1, 1'b1, 1);
`endif
        clk_edge();
        idle();
        #1;
        chk_all("byp_after", 32'h20, 32'h20, 1'b0, 1'b0, 0);

        // Randomized run against the model, checking combinational outputs before each edge
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            RegWrite   = ($urandom_range(0, 99) < 45);
            WriteReg   = AW'($urandom_range(0, 11));
            WriteData  = $urandom;
            Reserve    = ($urandom_range(0, 99) < 50);
            ReserveReg = AW'($urandom_range(0, 11));
            ReadReg1   = AW'($urandom_range(0, 11));
            ReadReg2   = ($urandom_range(0, 3) == 0) ? ReadReg1 : AW'($urandom_range(0, 11));
            #1;
            chk_all($sformatf("rnd%0d", n), exp_rd(ReadReg1), exp_rd(ReadReg2),
                    exp_busy(ReadReg1), exp_busy(ReadReg2), exp_cnt());
            @(posedge CLK);
            model_edge();
        end
        @(negedge CLK);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
